// File: rtl/cp_drv.sv
// -----------------------------------------------------------------------------
// cp_drv : clocked charge-pump driver for the CDR loop filter.
//
// Turns the bang-bang phase detector's sampled up/dn decisions into a current
// injected on the loop-filter node. It enforces a dead time after every pump
// burst, limits the burst length, and clamps the current when the node voltage
// is outside the pump's compliance range. A saturating net-charge counter is
// kept for loop monitoring.
//
// Loop-filter node (EEnet {V, I, R}) in fixed point:
//   out_v   in   node voltage in mV (unsigned), observed from the filter model
//   out_i   out  injected current in nA (signed, positive charges the node)
//   out_r   out  output resistance in ohms, constant RO
//   out_vz  out  always 1: the pump never drives the node voltage
//               (the V field is wrealZState)
//
// Ports:
//   clk     in   sampling clock, rising edge active
//   rst_n   in   asynchronous active-low reset
//   up      in   phase detector "late" decision
//   dn      in   phase detector "early" decision
//   state   out  0=IDLE 1=SRC 2=SNK 3=DEAD
//   net_q   out  signed net delivered pump cycles, saturating at 16 bits
//   sat     out  current state is clamped by compliance
//   pw      out  cycles spent in the current SRC/SNK burst (0 otherwise)
//
// Handshake: none. up/dn are plain level inputs sampled at every rising edge.
// The new state and current take effect right after that edge.
// -----------------------------------------------------------------------------
module cp_drv #(
  parameter int IUP_NA      = 100000,   // source current, nA
  parameter int IDN_NA      = 100000,   // sink current, nA
  parameter int RO_OHM      = 1000000,  // output resistance, ohms
  parameter int VCOMP_HI_MV = 1100,     // no sourcing at or above this, mV
  parameter int VCOMP_LO_MV = 100,      // no sinking at or below this, mV
  parameter int MAXPW       = 8,        // 1..255
  parameter int DEADT       = 1         // 1..15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up,
  input  logic               dn,
  input  logic [15:0]        out_v,
  output logic signed [31:0] out_i,
  output logic [31:0]        out_r,
  output logic               out_vz,
  output logic [1:0]         state,
  output logic signed [15:0] net_q,
  output logic               sat,
  output logic [7:0]         pw
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SRC  = 2'd1;
  localparam logic [1:0] ST_SNK  = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  localparam logic [7:0]         MAXPW_L = 8'(MAXPW);
  localparam logic [3:0]         DEADT_L = 4'(DEADT);
  localparam logic [15:0]        V_HI    = 16'(VCOMP_HI_MV);
  localparam logic [15:0]        V_LO    = 16'(VCOMP_LO_MV);
  localparam logic signed [31:0] I_SRC   = 32'(IUP_NA);
  localparam logic signed [31:0] I_SNK   = -(32'(IDN_NA));
  localparam logic signed [15:0] NET_MAX = 16'sh7FFF;
  localparam logic signed [15:0] NET_MIN = 16'sh8000;

  logic [1:0] state_q, state_d;
  logic [7:0] pw_q, pw_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic       sat_start_q;   // clamp status at the start of the current cycle
  logic       up_s, dn_s;
  logic [1:0] idle_state;
  logic [7:0] idle_pw;
  logic       deliver;

  // Only a clean 1 counts as a decision. X or Z from the detector reads as 0.
  assign up_s = (up === 1'b1);
  assign dn_s = (dn === 1'b1);

  // Compliance clamp for a given state and node voltage.
  function automatic logic clamp_of(input logic [1:0] s, input logic [15:0] v);
    logic c;
    c = 1'b0;
    if (s == ST_SRC && v >= V_HI) c = 1'b1;
    if (s == ST_SNK && v <= V_LO) c = 1'b1;
    return c;
  endfunction

  // Decision rules used from IDLE and from the last DEAD cycle. If up and dn
  // are both high, the decision is cancelled.
  always_comb begin
    idle_state = ST_IDLE;
    idle_pw    = 8'd0;
    if (up_s && !dn_s) begin
      idle_state = ST_SRC;
      idle_pw    = 8'd1;
    end else if (dn_s && !up_s) begin
      idle_state = ST_SNK;
      idle_pw    = 8'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = idle_state;
        pw_d    = idle_pw;
      end
      ST_SRC: begin
        if (up_s && !dn_s && pw_q < MAXPW_L) begin
          pw_d = pw_q + 8'd1;
        end else begin
          state_d = ST_DEAD;
          dcnt_d  = DEADT_L;
          pw_d    = 8'd0;
        end
      end
      ST_SNK: begin
        if (dn_s && !up_s && pw_q < MAXPW_L) begin
          pw_d = pw_q + 8'd1;
        end else begin
          state_d = ST_DEAD;
          dcnt_d  = DEADT_L;
          pw_d    = 8'd0;
        end
      end
      default: begin
        // DEAD. On the edge where the counter expires, the IDLE rules apply
        // directly, so a new burst starts without an extra idle cycle.
        if (dcnt_q <= 4'd1) begin
          dcnt_d  = 4'd0;
          state_d = idle_state;
          pw_d    = idle_pw;
        end else begin
          dcnt_d = dcnt_q - 4'd1;
        end
      end
    endcase
  end

  // Clamp is combinational on the node voltage, so it reacts mid-cycle.
  assign sat = clamp_of(state_q, out_v);

  // A cycle delivers charge only if it was unclamped at both its start and its
  // end. A clamp that appears and clears entirely inside one cycle is not seen.
  assign deliver = !sat && !sat_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pw_q        <= 8'd0;
      dcnt_q      <= 4'd0;
      sat_start_q <= 1'b0;
      net_q       <= 16'sd0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      dcnt_q      <= dcnt_d;
      sat_start_q <= clamp_of(state_d, out_v);
      if (state_q == ST_SRC && deliver && net_q != NET_MAX)
        net_q <= net_q + 16'sd1;
      else if (state_q == ST_SNK && deliver && net_q != NET_MIN)
        net_q <= net_q - 16'sd1;
    end
  end

  // The current follows the registered state, so reset zeroes it at once.
  always_comb begin
    out_i = 32'sd0;
    if (state_q == ST_SRC && !sat) out_i = I_SRC;
    if (state_q == ST_SNK && !sat) out_i = I_SNK;
  end

  assign out_r  = 32'(RO_OHM);
  assign out_vz = 1'b1;
  assign state  = state_q;
  assign pw     = pw_q;

endmodule

// File: tb/tb_cp_drv.sv
module tb_cp_drv;

  logic        clk;
  logic        rst_n;
  logic        up;
  logic        dn;
  logic [15:0] out_v;

  logic signed [31:0] a_out_i, b_out_i;
  logic [31:0]        a_out_r, b_out_r;
  logic               a_out_vz, b_out_vz;
  logic [1:0]         a_state, b_state;
  logic signed [15:0] a_net, b_net;
  logic               a_sat, b_sat;
  logic [7:0]         a_pw, b_pw;

  int n_chk;
  int n_fail;

  // Directed tests run on u_dut with MAXPW=8.
  cp_drv #(.MAXPW(8), .DEADT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .up(up), .dn(dn), .out_v(out_v),
    .out_i(a_out_i), .out_r(a_out_r), .out_vz(a_out_vz),
    .state(a_state), .net_q(a_net), .sat(a_sat), .pw(a_pw)
  );

  // Counter saturation runs on u_sat with MAXPW=255.
  cp_drv #(.MAXPW(255), .DEADT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .up(up), .dn(dn), .out_v(out_v),
    .out_i(b_out_i), .out_r(b_out_r), .out_vz(b_out_vz),
    .state(b_state), .net_q(b_net), .sat(b_sat), .pw(b_pw)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    up    = 1'b0;
    dn    = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_st [20];
  logic [7:0] exp_pw [20];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    up     = 1'b0;
    dn     = 1'b0;
    out_v  = 16'd500;

    exp_st = '{1,1,1,1,1,1,1,1,3,1,1,1,1,1,1,1,1,3,1,1};
    exp_pw = '{1,2,3,4,5,6,7,8,0,1,2,3,4,5,6,7,8,0,1,2};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_state", a_state, 0);
    check("rst_net", a_net, 0);
    check("rst_sat", a_sat, 0);
    check("rst_pw", a_pw, 0);
    check("rst_iout", a_out_i, 0);
    check("rst_r", a_out_r, 1000000);
    check("rst_vz", a_out_vz, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single up burst of 3
    up = 1'b1;
    step(); check("t1_st1", a_state, 1); check("t1_pw1", a_pw, 1);
    check("t1_i1", a_out_i, 100000);
    step(); check("t1_st2", a_state, 1); check("t1_pw2", a_pw, 2);
    step(); check("t1_st3", a_state, 1); check("t1_pw3", a_pw, 3);
    up = 1'b0;
    step(); check("t1_dead", a_state, 3); check("t1_pw0", a_pw, 0);
    check("t1_idead", a_out_i, 0); check("t1_net", a_net, 3);
    step(); check("t1_idle", a_state, 0); check("t1_net2", a_net, 3);

    // Max pulse width, bursts restart straight out of DEAD
    do_reset();
    up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("t2_st%0d", i + 1), a_state, exp_st[i]);
      check($sformatf("t2_pw%0d", i + 1), a_pw, exp_pw[i]);
    end
    up = 1'b0;
    step(); check("t2_dead", a_state, 3); check("t2_net", a_net, 18);

    // Cancelled decisions, then reversal through DEAD
    do_reset();
    up = 1'b1; dn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_cancel_st", a_state, 0);
      check("t3_cancel_i", a_out_i, 0);
    end
    check("t3_cancel_net", a_net, 0);
    dn = 1'b0;
    step(); check("t3_src1", a_state, 1);
    step(); check("t3_src2", a_state, 1); check("t3_isrc", a_out_i, 100000);
    up = 1'b0; dn = 1'b1;
    step(); check("t3_dead", a_state, 3); check("t3_idead", a_out_i, 0);
    step(); check("t3_snk", a_state, 2); check("t3_isnk", a_out_i, -100000);
    check("t3_snkpw", a_pw, 1);
    dn = 1'b0;
    step(); check("t3_dead2", a_state, 3); check("t3_net", a_net, 1);

    // X on up is ignored
    step();
    up = 1'bx;
    step(); check("tx_idle", a_state, 0);
    up = 1'b0;

    // Source compliance clamp
    do_reset();
    out_v = 16'd1200;
    up    = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t4_st", a_state, 1);
      check("t4_pw", a_pw, i);
      check("t4_sat", a_sat, 1);
      check("t4_i", a_out_i, 0);
    end
    #4 out_v = 16'd1000;
    #1;
    check("t4_resume_i", a_out_i, 100000);
    check("t4_resume_sat", a_sat, 0);
    up = 1'b0;
    step(); check("t4_dead", a_state, 3); check("t4_net", a_net, 0);

    // Sink compliance clamp
    do_reset();
    out_v = 16'd80;
    dn    = 1'b1;
    step(); check("t4s_st", a_state, 2); check("t4s_sat", a_sat, 1);
    check("t4s_i", a_out_i, 0);
    dn    = 1'b0;
    out_v = 16'd500;
    step(); check("t4s_net", a_net, 0);

    // Asynchronous reset in the middle of an SNK burst
    do_reset();
    dn = 1'b1;
    step(); check("t5_snk1", a_state, 2);
    step(); check("t5_snk2", a_pw, 2); check("t5_net_pre", a_net, -1);
    check("t5_i_pre", a_out_i, -100000);
    #4 rst_n = 1'b0;
    #1;
    check("t5_st", a_state, 0);
    check("t5_i", a_out_i, 0);
    check("t5_net", a_net, 0);
    check("t5_pw", a_pw, 0);
    dn = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Net-charge saturation on the MAXPW=255 instance
    do_reset();
    up = 1'b1;
    repeat (256) step();
    check("t6_dead", b_state, 3);
    check("t6_net255", b_net, 255);
    repeat (32900) step();
    check("t6_net_sat", b_net, 32767);
    up = 1'b0;
    step();
    step();
    check("t6_net_hold", b_net, 32767);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
